axi_lite_regbank: RTL and testbench
===================================

AXI_LITE_REGBANK -- requirements
Module: axi_lite_regbank

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 32, AXI data bus width; legal values are 32 and 64.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 6, byte-address width.
REQ-003 SHALL have parameter NUM_REGS, default 16, register count, at most 2^(AXI_ADDR_WIDTH-log2(AXI_DATA_WIDTH/8)).
REQ-004 SHALL have parameter RO_MASK, default 0, NUM_REGS bits; bit i=1 makes register i read-only.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  clock; reset_n  in  1  async active-low reset.
REQ-006 SHALL have slave write ports: AWADDR in ADDR_W, AWVALID in 1, AWREADY out 1, WDATA in DATA_W, WSTRB in DATA_W/8, WVALID in 1, WREADY out 1, BRESP out 2, BVALID out 1, BREADY in 1.
REQ-007 SHALL have slave read ports: ARADDR in ADDR_W, ARVALID in 1, ARREADY out 1, RDATA out DATA_W, RRESP out 2, RVALID out 1, RREADY in 1.
REQ-008 SHALL have user ports: reg_q out NUM_REGS*DATA_W (flat register contents), reg_d in NUM_REGS*DATA_W (read value for RO registers), wr_pulse out NUM_REGS (one-cycle strobe per committed write).

Function
REQ-009 SHALL decode the register index as ADDR[ADDR_W-1:log2(DATA_W/8)], ignoring the byte-offset bits.
REQ-010 SHALL accept AW and W independently, in either order, each into a one-entry holding register; AWREADY/WREADY SHALL be high only while that holding register is empty and BVALID is low.
REQ-011 SHALL commit the write in the cycle after both holding registers are full, merging WDATA byte-wise under WSTRB, and SHALL pulse wr_pulse[i] in that same cycle.
REQ-012 SHALL assert BVALID in the commit cycle, hold BVALID and BRESP stable until BREADY, then empty both holding registers.
REQ-013 SHALL return BRESP=OKAY(00), or SLVERR(10) with no state change and no wr_pulse when the index is >= NUM_REGS or RO_MASK[i]=1.
REQ-014 SHALL implement the write FSM as W_IDLE (collect AW/W) -> W_COMMIT (one cycle) -> W_RESP (wait BREADY) -> W_IDLE.
REQ-015 SHALL implement the read FSM as R_IDLE (ARREADY=1) -> on ARVALID, R_DATA the next cycle, with RVALID=1 and registered RDATA/RRESP -> R_IDLE on RREADY.
REQ-016 SHALL return reg_d slice i for RO registers and the stored value otherwise; an out-of-range read SHALL return RDATA=0 and RRESP=SLVERR.
REQ-017 SHALL, when a read and a commit target the same register in the same cycle, return the pre-write value.
REQ-018 SHALL hold RDATA and RRESP stable while RVALID=1 and RREADY=0.
REQ-019 SHALL allow the read and write channels to progress concurrently, with no mutual stalls.

Reset
REQ-020 SHALL drive, while reset_n=0: all registers 0, reg_q=0, wr_pulse=0, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, and all READYs 0.
REQ-021 SHALL set AWREADY, WREADY and ARREADY to 1 on the first clk edge after reset_n deasserts.
REQ-022 SHALL, on reset mid-transaction, discard held AW/W and pending responses, with no commit.

Structure
REQ-023 SHALL place in shared package axi_lite_pkg: the resp enum (OKAY, SLVERR), the write/read state typedefs, and a byte-strobe merge function.
REQ-024 SHALL contain no sub-module, since the regbank is a single flat module.

Verification
REQ-025 SHALL cover write 0xDEADBEEF to 0x08 with WSTRB=0xF, then read 0x08 -> RDATA=0xDEADBEEF, RRESP=00, wr_pulse[2] high for one cycle.
REQ-026 SHALL cover W issued 3 cycles before AW, to 0x04 with WSTRB=0x3 over a prior value of 0x11223344, data 0xAAAABBBB -> readback 0x1122BBBB.
REQ-027 SHALL cover a write to 0x40 with NUM_REGS=16 -> BRESP=10, no wr_pulse; a read of 0x40 -> RDATA=0, RRESP=10.
REQ-028 SHALL cover RO_MASK bit 1 with reg_d[1]=0x5A5A5A5A: a write to 0x04 -> BRESP=10; a read -> 0x5A5A5A5A.
REQ-029 SHALL cover BREADY and RREADY held low for 5 cycles -> BVALID/RVALID and their data stable, AWREADY=WREADY=0 throughout.
REQ-030 SHALL cover reset_n asserted between AW acceptance and W -> after release, no commit, reg_q=0, and AWREADY=1 one cycle later.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite types: response codes, register-bank FSM state encodings
// and the byte-lane merge helper used on register writes.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } axi_resp_e;

  typedef enum logic [1:0] {
    W_IDLE   = 2'b00,
    W_COMMIT = 2'b01,
    W_RESP   = 2'b10
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  // Byte-wise merge of new data over old data. Widths are fixed at the
  // widest legal bus (64 bits); narrower callers zero-extend and truncate.
  function automatic logic [63:0] strb_merge(input logic [63:0] old_v,
                                             input logic [63:0] new_v,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    res = old_v;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_regbank.sv
// AXI-Lite slave register bank: NUM_REGS words, optional read-only words
// sourced from reg_d, per-register write strobe, independent read/write paths.
//
// Handshake rule for every channel (AW, W, B, AR, R): a transfer happens on
// the rising clk edge where VALID and READY are both 1. Once raised, VALID and
// its payload stay stable until that edge; READY never depends on VALID.
module axi_lite_regbank
  import axi_lite_pkg::*;
#(
  parameter int                  AXI_DATA_WIDTH = 32,
  parameter int                  AXI_ADDR_WIDTH = 6,
  parameter int                  NUM_REGS       = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK        = '0
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [AXI_ADDR_WIDTH-1:0]          AWADDR,
  input  logic                               AWVALID,
  output logic                               AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0]          WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                               WVALID,
  output logic                               WREADY,
  output logic [1:0]                         BRESP,
  output logic                               BVALID,
  input  logic                               BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]          ARADDR,
  input  logic                               ARVALID,
  output logic                               ARREADY,
  output logic [AXI_DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                         RRESP,
  output logic                               RVALID,
  input  logic                               RREADY,
  output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] reg_q,
  input  logic [NUM_REGS*AXI_DATA_WIDTH-1:0] reg_d,
  output logic [NUM_REGS-1:0]                wr_pulse,
  output w_state_t                           dbg_w_state,
  output r_state_t                           dbg_r_state
);

  localparam int DW       = AXI_DATA_WIDTH;
  localparam int STRB_W   = AXI_DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = AXI_ADDR_WIDTH - ADDR_LSB;

  w_state_t          w_state, w_state_nxt;
  r_state_t          r_state, r_state_nxt;
  logic              live;
  logic              aw_full, w_full;
  logic [IDX_W-1:0]  aw_idx;
  logic [DW-1:0]     w_data;
  logic [STRB_W-1:0] w_strb;
  logic [DW-1:0]     regs [NUM_REGS];
  logic [DW-1:0]     rdata_q;
  logic [1:0]        rresp_q;
  logic [IDX_W-1:0]  ar_idx;
  logic              aw_hs, w_hs, b_hs, ar_hs;
  logic              wr_err, rd_err;
  logic [DW-1:0]     wr_old, wr_merged, rd_val;
  logic              unused_ok;

  assign ar_idx    = ARADDR[AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign unused_ok = ^{AWADDR[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0], reg_d};

  // READYs stay low until the first edge after reset release.
  assign AWREADY = live && (w_state == W_IDLE) && !aw_full;
  assign WREADY  = live && (w_state == W_IDLE) && !w_full;
  assign BVALID  = (w_state == W_COMMIT) || (w_state == W_RESP);
  assign BRESP   = (BVALID && wr_err) ? SLVERR : OKAY;
  assign ARREADY = live && (r_state == R_IDLE);
  assign RVALID  = (r_state == R_DATA);
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign b_hs  = BVALID && BREADY;
  assign ar_hs = ARVALID && ARREADY;

  assign dbg_w_state = w_state;
  assign dbg_r_state = r_state;

  // Marks the bank as live one edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) live <= 1'b0;
    else          live <= 1'b1;
  end

  // Write FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) w_state <= W_IDLE;
    else          w_state <= w_state_nxt;
  end

  // Write FSM next state: commit as soon as both halves are held; a BREADY
  // already high in the commit cycle completes the response there.
  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:   if ((aw_full || aw_hs) && (w_full || w_hs)) w_state_nxt = W_COMMIT;
      W_COMMIT: w_state_nxt = BREADY ? W_IDLE : W_RESP;
      W_RESP:   if (BREADY) w_state_nxt = W_IDLE;
      default:  w_state_nxt = W_IDLE;
    endcase
  end

  // AW and W one-entry holding registers, emptied by the B handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aw_full <= 1'b0;
      aw_idx  <= '0;
      w_full  <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
    end else if (b_hs) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_idx  <= AWADDR[AXI_ADDR_WIDTH-1:ADDR_LSB];
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= WDATA;
        w_strb <= WSTRB;
      end
    end
  end

  // Write target lookup: out-of-range or read-only targets are errors.
  always_comb begin
    wr_err   = 1'b1;
    wr_old   = '0;
    wr_pulse = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (aw_idx == IDX_W'(i)) begin
        wr_old = regs[i];
        wr_err = RO_MASK[i];
        wr_pulse[i] = (w_state == W_COMMIT) && !RO_MASK[i];
      end
    end
    wr_merged = DW'(strb_merge(64'(wr_old), 64'(w_data), 8'(w_strb)));
  end

  // Register storage, updated at the end of the commit cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_pulse[i]) regs[i] <= wr_merged;
      end
    end
  end

  // Flatten register contents onto reg_q.
  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_q[i*DW +: DW] = regs[i];
  end

  // Read source select: reg_d for read-only words, storage otherwise.
  always_comb begin
    rd_val = '0;
    rd_err = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) begin
        rd_err = 1'b0;
        rd_val = RO_MASK[i] ? reg_d[i*DW +: DW] : regs[i];
      end
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= R_IDLE;
    else          r_state <= r_state_nxt;
  end

  // Read FSM next state.
  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
      R_DATA:  if (RREADY) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Read data capture; sampling storage at the same edge as a commit
  // naturally returns the pre-write value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
      rresp_q <= OKAY;
    end else if (ar_hs) begin
      rdata_q <= rd_err ? '0 : rd_val;
      rresp_q <= rd_err ? SLVERR : OKAY;
    end
  end

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Directed bench for axi_lite_regbank. Two instances share every input:
// dut_a has no read-only registers, dut_b makes register 1 read-only.
module tb_axi_lite_regbank;
  import axi_lite_pkg::*;

  localparam int DW = 32;
  localparam int AW = 7;
  localparam int NR = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // shared inputs
  logic [AW-1:0]    AWADDR;
  logic             AWVALID;
  logic [DW-1:0]    WDATA;
  logic [DW/8-1:0]  WSTRB;
  logic             WVALID;
  logic             BREADY;
  logic [AW-1:0]    ARADDR;
  logic             ARVALID;
  logic             RREADY;
  logic [NR*DW-1:0] reg_d;

  // dut_a outputs
  logic AWREADY_a, WREADY_a, BVALID_a, ARREADY_a, RVALID_a;
  logic [1:0] BRESP_a, RRESP_a;
  logic [DW-1:0] RDATA_a;
  logic [NR*DW-1:0] reg_q_a;
  logic [NR-1:0] wr_pulse_a;
  w_state_t dbg_w_a;
  r_state_t dbg_r_a;

  // dut_b outputs
  logic AWREADY_b, WREADY_b, BVALID_b, ARREADY_b, RVALID_b;
  logic [1:0] BRESP_b, RRESP_b;
  logic [DW-1:0] RDATA_b;
  logic [NR*DW-1:0] reg_q_b;
  logic [NR-1:0] wr_pulse_b;
  w_state_t dbg_w_b;
  r_state_t dbg_r_b;

  axi_lite_regbank #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .NUM_REGS(NR),
                     .RO_MASK(16'h0000)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY_a),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY_a),
    .BRESP(BRESP_a), .BVALID(BVALID_a), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY_a),
    .RDATA(RDATA_a), .RRESP(RRESP_a), .RVALID(RVALID_a), .RREADY(RREADY),
    .reg_q(reg_q_a), .reg_d(reg_d), .wr_pulse(wr_pulse_a),
    .dbg_w_state(dbg_w_a), .dbg_r_state(dbg_r_a)
  );

  axi_lite_regbank #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .NUM_REGS(NR),
                     .RO_MASK(16'h0002)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY_b),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY_b),
    .BRESP(BRESP_b), .BVALID(BVALID_b), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY_b),
    .RDATA(RDATA_b), .RRESP(RRESP_b), .RVALID(RVALID_b), .RREADY(RREADY),
    .reg_q(reg_q_b), .reg_d(reg_d), .wr_pulse(wr_pulse_b),
    .dbg_w_state(dbg_w_b), .dbg_r_state(dbg_r_b)
  );

  // ---------------- scoreboard ----------------
  int total_cnt = 0;
  int bad_cnt   = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One write; W leads AW by w_lead cycles, BREADY held off b_delay cycles.
  task automatic do_write(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [3:0] strb, input int w_lead, input int b_delay,
                          input logic [1:0] exp_resp, input logic [NR-1:0] exp_pul,
                          output logic [1:0] resp_b, output logic [NR-1:0] pul_b);
    bit aw_done, w_done, got_b;
    int npulse;
    logic [1:0] resp_a;
    logic [NR-1:0] pul_a;
    aw_done = 0; w_done = 0; got_b = 0; npulse = 0;
    pul_a = '0; pul_b = '0; resp_a = 2'b11; resp_b = 2'b11;
    for (int c = 0; c < 40 && !got_b; c++) begin
      @(negedge clk);
      pul_a |= wr_pulse_a;
      pul_b |= wr_pulse_b;
      if (wr_pulse_a != '0) npulse++;
      if (BVALID_a) begin
        got_b = 1; resp_a = BRESP_a; resp_b = BRESP_b;
      end
      AWADDR  = addr;
      AWVALID = !aw_done && (c >= w_lead);
      WDATA   = data;
      WSTRB   = strb;
      WVALID  = !w_done;
      if (AWVALID && AWREADY_a) aw_done = 1;
      if (WVALID && WREADY_a) w_done = 1;
    end
    check_val({tag, "_b_seen"}, got_b, 1);
    for (int s = 0; s < b_delay; s++) begin
      @(negedge clk);
      check_val({tag, "_bvalid_hold"}, BVALID_a, 1);
      check_val({tag, "_bresp_hold"}, BRESP_a, exp_resp);
      check_val({tag, "_awready_stall"}, AWREADY_a, 0);
      check_val({tag, "_wready_stall"}, WREADY_a, 0);
      if (wr_pulse_a != '0) npulse++;
    end
    BREADY = 1'b1;
    @(negedge clk);
    BREADY = 1'b0;
    if (wr_pulse_a != '0) npulse++;
    check_val({tag, "_bresp"}, resp_a, exp_resp);
    check_val({tag, "_wr_pulse"}, pul_a, exp_pul);
    check_val({tag, "_pulse_len"}, npulse, (exp_pul != '0) ? 1 : 0);
    check_val({tag, "_bvalid_drop"}, BVALID_a, 0);
  endtask

  // One read; AR delayed by ar_lead cycles, RREADY held off r_delay cycles.
  task automatic do_read(input logic [AW-1:0] addr, input int ar_lead, input int r_delay,
                         output logic [DW-1:0] data_a, output logic [1:0] resp_a,
                         output logic [DW-1:0] data_b, output logic [1:0] resp_b);
    bit ar_done, got_r;
    ar_done = 0; got_r = 0;
    data_a = '0; resp_a = 2'b11; data_b = '0; resp_b = 2'b11;
    for (int k = 0; k < ar_lead; k++) @(negedge clk);
    for (int c = 0; c < 40 && !got_r; c++) begin
      @(negedge clk);
      if (RVALID_a) begin
        got_r = 1; data_a = RDATA_a; resp_a = RRESP_a; data_b = RDATA_b; resp_b = RRESP_b;
      end
      ARADDR  = addr;
      ARVALID = !ar_done;
      if (ARVALID && ARREADY_a) ar_done = 1;
    end
    check_val("r_seen", got_r, 1);
    for (int s = 0; s < r_delay; s++) begin
      @(negedge clk);
      check_val("rvalid_hold", RVALID_a, 1);
      check_val("rdata_hold", RDATA_a, data_a);
      check_val("rresp_hold", RRESP_a, resp_a);
      check_val("arready_stall", ARREADY_a, 0);
    end
    RREADY = 1'b1;
    @(negedge clk);
    RREADY = 1'b0;
    check_val("rvalid_drop", RVALID_a, 0);
  endtask

  task automatic read_check(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] exp_d,
                            input logic [1:0] exp_r, input int r_delay);
    logic [DW-1:0] d_a, d_b;
    logic [1:0] r_a, r_b;
    exp_q.push_back(exp_d);
    do_read(addr, 0, r_delay, d_a, r_a, d_b, r_b);
    check_val({tag, "_rdata"}, d_a, exp_q.pop_front());
    check_val({tag, "_rresp"}, r_a, exp_r);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] rb, r_a, r_b;
    logic [NR-1:0] pb;
    logic [DW-1:0] d_a, d_b;

    reset_n = 1'b1;
    AWADDR = '0; AWVALID = 0; WDATA = '0; WSTRB = '0; WVALID = 0; BREADY = 0;
    ARADDR = '0; ARVALID = 0; RREADY = 0;
    reg_d = '0;
    reg_d[1*DW +: DW] = 32'h5A5A5A5A;
    #3 reset_n = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check_val("rst_awready", AWREADY_a, 0);
    check_val("rst_wready", WREADY_a, 0);
    check_val("rst_arready", ARREADY_a, 0);
    check_val("rst_bvalid", BVALID_a, 0);
    check_val("rst_rvalid", RVALID_a, 0);
    check_val("rst_bresp", BRESP_a, 0);
    check_val("rst_rresp", RRESP_a, 0);
    check_val("rst_rdata", RDATA_a, 0);
    check_val("rst_reg_q", (reg_q_a == '0), 1);
    check_val("rst_wr_pulse", wr_pulse_a, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check_val("rel_awready", AWREADY_a, 1);
    check_val("rel_wready", WREADY_a, 1);
    check_val("rel_arready", ARREADY_a, 1);

    // full-word write and readback
    do_write("wr_deadbeef", 7'h08, 32'hDEADBEEF, 4'hF, 0, 0, 2'b00, 16'h0004, rb, pb);
    check_val("reg_q2", reg_q_a[2*DW +: DW], 32'hDEADBEEF);
    read_check("rd_deadbeef", 7'h08, 32'hDEADBEEF, 2'b00, 0);

    // W ahead of AW, partial strobe over a prior value
    do_write("wr_prior", 7'h04, 32'h11223344, 4'hF, 0, 0, 2'b00, 16'h0002, rb, pb);
    do_write("wr_w_first", 7'h04, 32'hAAAABBBB, 4'h3, 3, 0, 2'b00, 16'h0002, rb, pb);
    read_check("rd_merge", 7'h04, 32'h1122BBBB, 2'b00, 0);

    // out-of-range index
    do_write("wr_oor", 7'h40, 32'h12345678, 4'hF, 0, 0, 2'b10, 16'h0000, rb, pb);
    read_check("rd_oor", 7'h40, 32'h00000000, 2'b10, 0);

    // read-only register on dut_b
    do_write("wr_ro", 7'h04, 32'h77777777, 4'hF, 0, 0, 2'b00, 16'h0002, rb, pb);
    check_val("ro_bresp", rb, 2'b10);
    check_val("ro_no_pulse", pb, 0);
    check_val("ro_reg_q", reg_q_b[1*DW +: DW], 32'h0);
    do_read(7'h04, 0, 0, d_a, r_a, d_b, r_b);
    check_val("ro_rdata", d_b, 32'h5A5A5A5A);
    check_val("ro_rresp", r_b, 2'b00);
    check_val("rw_rdata", d_a, 32'h77777777);

    // byte-offset bits ignored, upper-half strobe
    do_write("wr_offs", 7'h0E, 32'h01020304, 4'hC, 0, 0, 2'b00, 16'h0008, rb, pb);
    read_check("rd_offs", 7'h0F, 32'h01020000, 2'b00, 0);

    // BREADY / RREADY held low for 5 cycles
    do_write("wr_stall", 7'h14, 32'hCAFEF00D, 4'hF, 0, 5, 2'b00, 16'h0020, rb, pb);
    read_check("rd_stall", 7'h14, 32'hCAFEF00D, 2'b00, 5);

    // read and commit on the same register in the same cycle
    fork
      do_write("wr_conc", 7'h08, 32'h12345678, 4'hF, 0, 0, 2'b00, 16'h0004, rb, pb);
      do_read(7'h08, 1, 0, d_a, r_a, d_b, r_b);
    join
    check_val("conc_prewrite", d_a, 32'hDEADBEEF);
    read_check("rd_conc_after", 7'h08, 32'h12345678, 2'b00, 0);

    // reset between AW acceptance and W
    @(negedge clk);
    AWADDR = 7'h18; AWVALID = 1'b1;
    @(negedge clk);
    AWVALID = 1'b0;
    check_val("aw_held", AWREADY_a, 0);
    reset_n = 1'b0;
    @(negedge clk);
    check_val("mid_rst_awready", AWREADY_a, 0);
    check_val("mid_rst_reg_q", (reg_q_a == '0), 1);
    reset_n = 1'b1;
    #1;
    check_val("rel_awready_early", AWREADY_a, 0);
    @(negedge clk);
    check_val("rel2_awready", AWREADY_a, 1);
    WDATA = 32'hFFFFFFFF; WSTRB = 4'hF; WVALID = 1'b1;
    @(negedge clk);
    WVALID = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("post_rst_no_pulse", wr_pulse_a, 0);
      check_val("post_rst_no_bvalid", BVALID_a, 0);
    end
    check_val("post_rst_reg_q", (reg_q_a == '0), 1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
